// File: rtl/rv_mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory arbiter slice.
package rv_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/rv_mem_arb_if.sv
// Fetch, load/store and downstream memory channels of the arbiter.
interface rv_mem_arb_if;
  import rv_mem_pkg::*;

  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_resp_valid;
  logic              i_resp_ready;
  logic [DATA_W-1:0] i_resp_rdata;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_wdata;
  logic [STRB_W-1:0] d_req_wstrb;
  logic              d_resp_valid;
  logic              d_resp_ready;
  logic [DATA_W-1:0] d_resp_rdata;

  logic              m_req_valid;
  logic              m_req_ready;
  logic [ADDR_W-1:0] m_req_addr;
  logic [DATA_W-1:0] m_req_wdata;
  logic [STRB_W-1:0] m_req_wstrb;
  logic              m_resp_valid;
  logic              m_resp_ready;
  logic [DATA_W-1:0] m_resp_rdata;

  // Arbiter view.
  modport slave (
    input  i_req_valid, i_req_addr, i_resp_ready,
    input  d_req_valid, d_req_addr, d_req_wdata, d_req_wstrb, d_resp_ready,
    input  m_req_ready, m_resp_valid, m_resp_rdata,
    output i_req_ready, i_resp_valid, i_resp_rdata,
    output d_req_ready, d_resp_valid, d_resp_rdata,
    output m_req_valid, m_req_addr, m_req_wdata, m_req_wstrb, m_resp_ready
  );

  // Core-plus-memory view.
  modport master (
    output i_req_valid, i_req_addr, i_resp_ready,
    output d_req_valid, d_req_addr, d_req_wdata, d_req_wstrb, d_resp_ready,
    output m_req_ready, m_resp_valid, m_resp_rdata,
    input  i_req_ready, i_resp_valid, i_resp_rdata,
    input  d_req_ready, d_resp_valid, d_resp_rdata,
    input  m_req_valid, m_req_addr, m_req_wdata, m_req_wstrb, m_resp_ready
  );

endinterface

// File: rtl/rv_mem_arb_arb2.sv
// Two-way grant: fixed D priority with starvation guard, or round-robin.
module rv_arb2
  import rv_mem_pkg::*;
#(
  parameter bit          D_PRIORITY = 1'b1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req_i_i,
  input  logic req_d_i,
  output logic gnt_i_o,
  output logic gnt_d_o
);

  localparam int unsigned CNT_W = (STARVE_MAX < 8) ? 3 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  port_e             rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              d_wins;

  always_comb begin
    d_wins       = 1'b0;
    rr_last_d    = rr_last_q;
    starve_cnt_d = starve_cnt_q;

    if (req_d_i && !req_i_i) begin
      d_wins = 1'b1;
    end else if (req_d_i && req_i_i) begin
      if (D_PRIORITY) d_wins = !((STARVE_MAX != 0) && (starve_cnt_q == CNT_MAX));
      else            d_wins = (rr_last_q == PORT_I);
    end

    gnt_d_o = en_i & req_d_i & d_wins;
    gnt_i_o = en_i & req_i_i & ~d_wins;

    // The counter only measures D grants taken while I was left waiting.
    if (gnt_i_o) begin
      rr_last_d    = PORT_I;
      starve_cnt_d = '0;
    end else if (gnt_d_o) begin
      rr_last_d = PORT_D;
      if (!req_i_i)                    starve_cnt_d = '0;
      else if (starve_cnt_q != CNT_MAX) starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q    <= PORT_D;
      starve_cnt_q <= '0;
    end else begin
      rr_last_q    <= rr_last_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/rv_mem_arb.sv
// Shares one single-ported memory between fetch (I) and load/store (D), one transaction at a time.
module rv_mem_arb
  import rv_mem_pkg::*;
#(
  parameter bit          D_PRIORITY = 1'b1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rv_mem_arb_if.slave  bus
);

  state_e            state_q, state_d;
  port_e             owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              gnt_i, gnt_d;
  logic              arb_en;

  // Gating with rst_n keeps both readies low while reset is held.
  assign arb_en = (state_q == IDLE) && rst_n;

  rv_arb2 #(
    .D_PRIORITY (D_PRIORITY),
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (arb_en),
    .req_i_i (bus.i_req_valid),
    .req_d_i (bus.d_req_valid),
    .gnt_i_o (gnt_i),
    .gnt_d_o (gnt_d)
  );

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    wstrb_d          = wstrb_q;
    bus.i_req_ready  = 1'b0;
    bus.d_req_ready  = 1'b0;
    bus.i_resp_valid = 1'b0;
    bus.d_resp_valid = 1'b0;
    bus.i_resp_rdata = '0;
    bus.d_resp_rdata = '0;
    bus.m_req_valid  = 1'b0;
    bus.m_req_addr   = addr_q;
    bus.m_req_wdata  = wdata_q;
    bus.m_req_wstrb  = wstrb_q;
    bus.m_resp_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.i_req_ready = gnt_i;
        bus.d_req_ready = gnt_d;
        if (gnt_d) begin
          owner_d = PORT_D;
          addr_d  = bus.d_req_addr;
          wdata_d = bus.d_req_wdata;
          wstrb_d = bus.d_req_wstrb;
          state_d = REQ;
        end else if (gnt_i) begin
          owner_d = PORT_I;
          addr_d  = bus.i_req_addr;
          wdata_d = '0;
          wstrb_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        bus.m_req_valid = 1'b1;
        if (bus.m_req_ready) state_d = RESP;
      end
      RESP: begin
        if (owner_q == PORT_I) begin
          bus.i_resp_valid = bus.m_resp_valid;
          bus.i_resp_rdata = bus.m_resp_rdata;
          bus.m_resp_ready = bus.i_resp_ready;
        end else begin
          bus.d_resp_valid = bus.m_resp_valid;
          bus.d_resp_rdata = bus.m_resp_rdata;
          bus.m_resp_ready = bus.d_resp_ready;
        end
        if (bus.m_resp_valid && bus.m_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= PORT_I;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Scoreboard bench: directed I/D traffic against a priority arbiter and a round-robin arbiter.
module tb_rv_mem_arb;
  import rv_mem_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mreq_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_mem_arb_if bus();
  rv_mem_arb_if bus_rr();

  rv_mem_arb #(.D_PRIORITY(1'b1), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  rv_mem_arb #(.D_PRIORITY(1'b0), .STARVE_MAX(4)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus_rr.slave));

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  port_e       exp_gnt[$];
  mreq_t       exp_m[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  port_e       rr_gnt[$];
  logic [31:0] rr_i[$];
  logic [31:0] rr_d[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got an event with nothing expected", name);
  endtask

  // ---------------- memory model for the priority DUT ----------------
  logic [31:0] mem [64];
  bit          rand_wait = 1'b0;
  logic        busy;
  int unsigned dly;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_req_ready  <= 1'b0;
      bus.m_resp_valid <= 1'b0;
      bus.m_resp_rdata <= '0;
      busy             <= 1'b0;
      dly              <= 0;
      for (int k = 0; k < 64; k++) mem[k] <= (k >= 12) ? (32'hA000_0000 | 32'(k)) : 32'h0;
      mem[4] <= 32'h0000_0013;
    end else if (busy) begin
      if (bus.m_resp_valid) begin
        if (bus.m_resp_ready) begin
          bus.m_resp_valid <= 1'b0;
          busy             <= 1'b0;
        end
      end else if (dly == 0) bus.m_resp_valid <= 1'b1;
      else dly <= dly - 1;
    end else if (bus.m_req_valid && bus.m_req_ready) begin
      bus.m_resp_rdata <= mem[bus.m_req_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (bus.m_req_wstrb[b]) mem[bus.m_req_addr[7:2]][b*8 +: 8] <= bus.m_req_wdata[b*8 +: 8];
      busy            <= 1'b1;
      bus.m_req_ready <= 1'b0;
      dly             <= rand_wait ? $urandom_range(3, 0) : 0;
    end else begin
      bus.m_req_ready <= rand_wait ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // ---------------- responder for the round-robin DUT: rdata = ~addr ----------------
  logic rr_busy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rr.m_req_ready  <= 1'b0;
      bus_rr.m_resp_valid <= 1'b0;
      bus_rr.m_resp_rdata <= '0;
      rr_busy             <= 1'b0;
    end else if (bus_rr.m_resp_valid) begin
      if (bus_rr.m_resp_ready) bus_rr.m_resp_valid <= 1'b0;
    end else if (rr_busy) begin
      bus_rr.m_resp_valid <= 1'b1;
      rr_busy             <= 1'b0;
    end else if (bus_rr.m_req_valid && bus_rr.m_req_ready) begin
      rr_busy             <= 1'b1;
      bus_rr.m_req_ready  <= 1'b0;
      bus_rr.m_resp_rdata <= ~bus_rr.m_req_addr;
    end else begin
      bus_rr.m_req_ready <= 1'b1;
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.i_req_valid && bus.i_req_ready) begin
        if (exp_gnt.size() == 0) unexpected("grant_I");
        else check("grant", 32'(PORT_I), 32'(exp_gnt.pop_front()));
        check("starve_cnt_le_max", 32'(dut.u_arb.starve_cnt_q > 3'd4), 32'd0);
      end
      if (bus.d_req_valid && bus.d_req_ready) begin
        if (exp_gnt.size() == 0) unexpected("grant_D");
        else check("grant", 32'(PORT_D), 32'(exp_gnt.pop_front()));
        check("starve_cnt_le_max", 32'(dut.u_arb.starve_cnt_q > 3'd4), 32'd0);
      end
      if (bus.m_req_valid && bus.m_req_ready) begin
        if (exp_m.size() == 0) unexpected("m_req");
        else begin
          mreq_t e;
          e = exp_m.pop_front();
          check("m_req_addr", bus.m_req_addr, e.addr);
          check("m_req_wdata", bus.m_req_wdata, e.wdata);
          check("m_req_wstrb", 32'(bus.m_req_wstrb), 32'(e.wstrb));
        end
      end
      if (bus.i_resp_valid && bus.i_resp_ready) begin
        if (exp_i.size() == 0) unexpected("i_resp");
        else check("i_resp_rdata", bus.i_resp_rdata, exp_i.pop_front());
      end
      if (bus.d_resp_valid && bus.d_resp_ready) begin
        if (exp_d.size() == 0) unexpected("d_resp");
        else check("d_resp_rdata", bus.d_resp_rdata, exp_d.pop_front());
      end
      if (bus.m_resp_valid)
        check("resp_routed_to_one_port", 32'(bus.i_resp_valid ^ bus.d_resp_valid), 32'd1);

      if (bus_rr.i_req_valid && bus_rr.i_req_ready) begin
        if (rr_gnt.size() == 0) unexpected("rr_grant_I");
        else check("rr_grant", 32'(PORT_I), 32'(rr_gnt.pop_front()));
      end
      if (bus_rr.d_req_valid && bus_rr.d_req_ready) begin
        if (rr_gnt.size() == 0) unexpected("rr_grant_D");
        else check("rr_grant", 32'(PORT_D), 32'(rr_gnt.pop_front()));
      end
      if (bus_rr.i_resp_valid && bus_rr.i_resp_ready) begin
        if (rr_i.size() == 0) unexpected("rr_i_resp");
        else check("rr_i_rdata", bus_rr.i_resp_rdata, rr_i.pop_front());
      end
      if (bus_rr.d_resp_valid && bus_rr.d_resp_ready) begin
        if (rr_d.size() == 0) unexpected("rr_d_resp");
        else check("rr_d_rdata", bus_rr.d_resp_rdata, rr_d.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic rdy(int unsigned sel, port_e p);
    if (sel == 0) return (p == PORT_I) ? bus.i_req_ready : bus.d_req_ready;
    return (p == PORT_I) ? bus_rr.i_req_ready : bus_rr.d_req_ready;
  endfunction

  task automatic drive(int unsigned sel, port_e p, logic v, logic [31:0] a,
                       logic [31:0] wd, logic [3:0] ws);
    if (sel == 0) begin
      if (p == PORT_I) begin bus.i_req_valid = v; bus.i_req_addr = a; end
      else begin
        bus.d_req_valid = v; bus.d_req_addr = a; bus.d_req_wdata = wd; bus.d_req_wstrb = ws;
      end
    end else begin
      if (p == PORT_I) begin bus_rr.i_req_valid = v; bus_rr.i_req_addr = a; end
      else begin
        bus_rr.d_req_valid = v; bus_rr.d_req_addr = a; bus_rr.d_req_wdata = wd; bus_rr.d_req_wstrb = ws;
      end
    end
  endtask

  // Present a request and wait for its accept; hold keeps valid high for the next call.
  task automatic issue(int unsigned sel, port_e p, logic [31:0] a, logic [31:0] wd,
                       logic [3:0] ws, bit hold);
    int unsigned t = 0;
    drive(sel, p, 1'b1, a, wd, ws);
    do begin @(negedge clk); t++; end while (!rdy(sel, p) && t < 400);
    if (!rdy(sel, p)) begin
      unexpected("accept_timeout");
      drive(sel, p, 1'b0, '0, '0, '0);
      return;
    end
    @(posedge clk); #1;
    if (!hold) drive(sel, p, 1'b0, '0, '0, '0);
  endtask

  task automatic drain();
    int unsigned t = 0;
    while ((exp_gnt.size() + exp_m.size() + exp_i.size() + exp_d.size() +
            rr_gnt.size() + rr_i.size() + rr_d.size()) != 0 && t < 400) begin
      @(negedge clk); t++;
    end
    if (t >= 400) unexpected("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic flush();
    exp_gnt.delete(); exp_m.delete(); exp_i.delete(); exp_d.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req_valid = 0; bus.i_req_addr = '0; bus.i_resp_ready = 1;
    bus.d_req_valid = 0; bus.d_req_addr = '0; bus.d_req_wdata = '0; bus.d_req_wstrb = '0;
    bus.d_resp_ready = 1;
    bus_rr.i_req_valid = 0; bus_rr.i_req_addr = '0; bus_rr.i_resp_ready = 1;
    bus_rr.d_req_valid = 0; bus_rr.d_req_addr = '0; bus_rr.d_req_wdata = '0;
    bus_rr.d_req_wstrb = '0; bus_rr.d_resp_ready = 1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({bus.i_req_ready, bus.d_req_ready, bus.i_resp_valid,
          bus.d_resp_valid, bus.m_req_valid, bus.m_resp_ready}), 32'd0);
    check("reset_m_fields", bus.m_req_addr | bus.m_req_wdata | 32'(bus.m_req_wstrb), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Lone I read of mem[4].
    exp_gnt.push_back(PORT_I);
    exp_m.push_back('{32'h10, 32'h0, 4'h0});
    exp_i.push_back(32'h0000_0013);
    issue(0, PORT_I, 32'h10, '0, '0, 0);
    drain();

    // D store returns the old word, then I reads the stored word.
    exp_gnt.push_back(PORT_D);
    exp_m.push_back('{32'h20, 32'hDEAD_BEEF, 4'hF});
    exp_d.push_back(32'h0);
    issue(0, PORT_D, 32'h20, 32'hDEAD_BEEF, 4'hF, 0);
    drain();
    exp_gnt.push_back(PORT_I);
    exp_m.push_back('{32'h20, 32'h0, 4'h0});
    exp_i.push_back(32'hDEAD_BEEF);
    issue(0, PORT_I, 32'h20, '0, '0, 0);
    drain();

    // Contention under D priority: D,D,D,D,I,D,D,D,D,I.
    for (int k = 0; k < 4; k++) begin
      exp_gnt.push_back(PORT_D);
      exp_m.push_back('{32'h40 + 32'(4*k), 32'h0, 4'h0});
      exp_d.push_back(32'hA000_0010 + 32'(k));
    end
    exp_gnt.push_back(PORT_I);
    exp_m.push_back('{32'h10, 32'h0, 4'h0});
    for (int k = 4; k < 8; k++) begin
      exp_gnt.push_back(PORT_D);
      exp_m.push_back('{32'h40 + 32'(4*k), 32'h0, 4'h0});
      exp_d.push_back(32'hA000_0010 + 32'(k));
    end
    exp_gnt.push_back(PORT_I);
    exp_m.push_back('{32'h60, 32'h0, 4'h0});
    exp_i.push_back(32'h0000_0013);
    exp_i.push_back(32'hA000_0018);
    fork
      begin
        issue(0, PORT_I, 32'h10, '0, '0, 1);
        issue(0, PORT_I, 32'h60, '0, '0, 0);
      end
      begin
        for (int k = 0; k < 8; k++) issue(0, PORT_D, 32'h40 + 32'(4*k), '0, '0, k < 7);
      end
    join
    drain();

    // Response backpressure on a D load while I is waiting.
    bus.d_resp_ready = 1'b0;
    exp_gnt.push_back(PORT_D);
    exp_m.push_back('{32'h50, 32'h0, 4'h0});
    exp_d.push_back(32'hA000_0014);
    issue(0, PORT_D, 32'h50, '0, '0, 0);
    begin
      int unsigned t = 0;
      do begin @(negedge clk); t++; end while (!bus.d_resp_valid && t < 50);
      if (!bus.d_resp_valid) unexpected("d_resp_timeout");
    end
    @(posedge clk); #1;
    exp_gnt.push_back(PORT_I);
    exp_m.push_back('{32'h10, 32'h0, 4'h0});
    exp_i.push_back(32'h0000_0013);
    drive(0, PORT_I, 1'b1, 32'h10, '0, '0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_d_resp_valid", 32'(bus.d_resp_valid), 32'd1);
      check("stall_i_req_ready", 32'(bus.i_req_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.d_resp_ready = 1'b1;
    @(negedge clk);
    check("release_d_resp_valid", 32'(bus.d_resp_valid), 32'd1);
    issue(0, PORT_I, 32'h10, '0, '0, 0);
    drain();

    // Reset while the request sits in REQ.
    rand_wait = 1'b1;
    exp_gnt.push_back(PORT_I);
    exp_m.push_back('{32'h10, 32'h0, 4'h0});
    issue(0, PORT_I, 32'h10, '0, '0, 0);
    begin
      int unsigned t = 0;
      do begin @(negedge clk); t++; end while (!bus.m_req_valid && t < 20);
      if (!bus.m_req_valid) unexpected("req_state_timeout");
    end
    rst_n = 1'b0;
    drive(0, PORT_I, 1'b1, 32'h10, '0, '0);
    drive(0, PORT_D, 1'b1, 32'h30, '0, '0);
    #1;
    check("async_reset_outputs", 32'({bus.i_req_ready, bus.d_req_ready, bus.i_resp_valid,
          bus.d_resp_valid, bus.m_req_valid, bus.m_resp_ready}), 32'd0);
    check("async_reset_fields", bus.m_req_addr | bus.m_req_wdata | 32'(bus.m_req_wstrb) |
          bus.i_resp_rdata | bus.d_resp_rdata, 32'd0);
    flush();
    drive(0, PORT_D, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    exp_gnt.push_back(PORT_I);
    exp_m.push_back('{32'h10, 32'h0, 4'h0});
    exp_i.push_back(32'h0000_0013);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset_i_ready", 32'(bus.i_req_ready), 32'd1);
    @(posedge clk); #1;
    drive(0, PORT_I, 1'b0, '0, '0, '0);
    drain();
    rand_wait = 1'b0;

    // Round-robin DUT: strict alternation starting with I.
    for (int k = 0; k < 3; k++) begin
      rr_gnt.push_back(PORT_I);
      rr_gnt.push_back(PORT_D);
      rr_i.push_back(~(32'h100 + 32'(4*k)));
      rr_d.push_back(~(32'h200 + 32'(4*k)));
    end
    fork
      begin
        for (int k = 0; k < 3; k++) issue(1, PORT_I, 32'h100 + 32'(4*k), '0, '0, k < 2);
      end
      begin
        for (int k = 0; k < 3; k++) issue(1, PORT_D, 32'h200 + 32'(4*k), '0, '0, k < 2);
      end
    join
    drain();

    check("queues_empty", 32'(exp_gnt.size() + exp_m.size() + exp_i.size() + exp_d.size() +
          rr_gnt.size() + rr_i.size() + rr_d.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
